sd_block_reader: RTL and testbench

SD_BLOCK_READER -- requirements
Module: sd_block_reader

---
 rtl/sd_block_reader_pkg.sv | 37 +++
 rtl/sd_block_reader_spi_byte.sv | 68 ++++++
 rtl/sd_block_reader.sv | 171 +++++++++++++++++
 tb/tb_sd_block_reader.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/sd_block_reader_pkg.sv
// Shared constants for the SD single-block (CMD17) reader: state codes,
// SPI protocol bytes and error codes.
package sd_block_reader_pkg;

  localparam logic [3:0] ST_INIT      = 4'd0;
  localparam logic [3:0] ST_WAIT_INIT = 4'd1;
  localparam logic [3:0] ST_READY     = 4'd2;
  localparam logic [3:0] ST_CMD       = 4'd3;
  localparam logic [3:0] ST_R1        = 4'd4;
  localparam logic [3:0] ST_TOKEN     = 4'd5;
  localparam logic [3:0] ST_DATA      = 4'd6;
  localparam logic [3:0] ST_CRC       = 4'd7;
  localparam logic [3:0] ST_FINISH    = 4'd8;
  localparam logic [3:0] ST_ERROR     = 4'd9;

  localparam logic [7:0] CMD17      = 8'h51;
  localparam logic [7:0] DATA_TOKEN = 8'hFE;
  localparam logic [7:0] IDLE_BYTE  = 8'hFF;

  localparam logic [1:0] ERR_NONE       = 2'd0;
  localparam logic [1:0] ERR_R1_TIMEOUT = 2'd1;
  localparam logic [1:0] ERR_R1_BAD     = 2'd2;
  localparam logic [1:0] ERR_TOKEN      = 2'd3;

  // CMD17 frame: opcode, 4 address bytes MSB first, dummy CRC byte.
  function automatic logic [7:0] cmd_byte(input logic [2:0] idx, input logic [31:0] addr);
    case (idx)
      3'd0:    return CMD17;
      3'd1:    return addr[31:24];
      3'd2:    return addr[23:16];
      3'd3:    return addr[15:8];
      3'd4:    return addr[7:0];
      default: return IDLE_BYTE;
    endcase
  endfunction

endpackage

// File: rtl/sd_block_reader_spi_byte.sv
// SPI mode-0 byte shifter: MOSI changes on SCLK fall, MISO sampled on SCLK rise,
// MSB first, each SCLK half-period lasting CLK_DIV clk cycles.
module sd_spi_byte #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_i,
  input  logic [7:0] byte_in_i,
  input  logic       miso_i,
  output logic [7:0] byte_out_o,
  output logic       busy_o,
  output logic       done_o,
  output logic       sclk_o,
  output logic       mosi_o
);
  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  logic [DW-1:0] div_q;
  logic [3:0]    half_q;
  logic [7:0]    tx_q, rx_q;
  logic          busy_q, done_q, sclk_q;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      div_q  <= '0;
      half_q <= '0;
      tx_q   <= 8'hFF;
      rx_q   <= '0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      sclk_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (!busy_q) begin
        if (start_i) begin
          busy_q <= 1'b1;
          tx_q   <= byte_in_i;
          div_q  <= '0;
          half_q <= '0;
        end
      end else if (div_q == DW'(CLK_DIV - 1)) begin
        div_q  <= '0;
        half_q <= half_q + 4'd1;
        if (!half_q[0]) begin
          sclk_q <= 1'b1;
          rx_q   <= {rx_q[6:0], miso_i};
        end else begin
          sclk_q <= 1'b0;
          tx_q   <= {tx_q[6:0], 1'b1};
          if (half_q == 4'd15) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
          end
        end
      end else begin
        div_q <= div_q + DW'(1);
      end
    end
  end

  assign byte_out_o = rx_q;
  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign sclk_o     = sclk_q;
  assign mosi_o     = busy_q ? tx_q[7] : 1'b1;

endmodule

// File: rtl/sd_block_reader.sv
// SD card single-block reader: hands the SPI pins to an external initializer,
// then serves CMD17 reads and streams the 512 payload bytes out.
module sd_block_reader
  import sd_block_reader_pkg::*;
#(
  parameter int CLK_DIV    = 4,
  parameter int R1_POLL    = 8,
  parameter int TOKEN_POLL = 4096
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        init_start,
  input  logic        init_done,
  input  logic        init_sclk,
  input  logic        init_di,
  input  logic        init_cs,
  output logic        SCLK,
  output logic        DI,
  output logic        CS,
  input  logic        DO,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  output logic        ready,
  output logic        data_valid,
  output logic [7:0]  data_out,
  output logic [8:0]  byte_idx,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] debug
);
  logic [3:0]  state_q, state_d;
  logic [12:0] cnt_q, cnt_d;
  logic [31:0] addr_q, addr_d;
  logic        init_start_q, init_start_d, sel_q, sel_d;
  logic        dv_q, dv_d, done_q, done_d, err_q, err_d;
  logic [7:0]  dout_q, dout_d;
  logic [8:0]  idx_q, idx_d;
  logic [1:0]  errc_q, errc_d;

  logic       xfer, cs_ctl, spi_start, spi_busy, spi_done, spi_sclk, spi_mosi;
  logic [7:0] tx_byte, rx;

  assign xfer      = state_q inside {ST_CMD, ST_R1, ST_TOKEN, ST_DATA, ST_CRC, ST_FINISH, ST_ERROR};
  assign cs_ctl    = !(state_q inside {ST_CMD, ST_R1, ST_TOKEN, ST_DATA, ST_CRC});
  // Launch the next byte once the previous completion has been consumed.
  assign spi_start = xfer && !spi_busy && !spi_done;
  assign tx_byte   = (state_q == ST_CMD) ? cmd_byte(cnt_q[2:0], addr_q) : IDLE_BYTE;

  sd_spi_byte #(.CLK_DIV(CLK_DIV)) u_spi (
    .clk        (clk),
    .reset_n    (reset_n),
    .start_i    (spi_start),
    .byte_in_i  (tx_byte),
    .miso_i     (DO),
    .byte_out_o (rx),
    .busy_o     (spi_busy),
    .done_o     (spi_done),
    .sclk_o     (spi_sclk),
    .mosi_o     (spi_mosi)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    init_start_d = init_start_q;
    sel_d        = sel_q;
    dv_d         = 1'b0;
    dout_d       = dout_q;
    idx_d        = idx_q;
    done_d       = 1'b0;
    err_d        = err_q;
    errc_d       = errc_q;
    case (state_q)
      ST_INIT: begin
        init_start_d = 1'b1;
        sel_d        = 1'b1;
        state_d      = ST_WAIT_INIT;
      end
      ST_WAIT_INIT: if (init_done) begin
        init_start_d = 1'b0;
        sel_d        = 1'b0;
        state_d      = ST_READY;
      end
      ST_READY: if (rd_req) begin
        addr_d  = rd_addr;
        err_d   = 1'b0;
        errc_d  = ERR_NONE;
        cnt_d   = '0;
        state_d = ST_CMD;
      end
      ST_CMD: if (spi_done) begin
        if (cnt_q == 13'd5) begin cnt_d = '0; state_d = ST_R1; end
        else cnt_d = cnt_q + 13'd1;
      end
      ST_R1: if (spi_done) begin
        if (!rx[7]) begin
          cnt_d = '0;
          if (rx == 8'h00) state_d = ST_TOKEN;
          else begin state_d = ST_ERROR; err_d = 1'b1; errc_d = ERR_R1_BAD; end
        end else if (cnt_q == 13'(R1_POLL - 1)) begin
          cnt_d = '0; state_d = ST_ERROR; err_d = 1'b1; errc_d = ERR_R1_TIMEOUT;
        end else cnt_d = cnt_q + 13'd1;
      end
      ST_TOKEN: if (spi_done) begin
        if (rx == DATA_TOKEN) begin cnt_d = '0; state_d = ST_DATA; end
        else if (rx != IDLE_BYTE || cnt_q == 13'(TOKEN_POLL - 1)) begin
          cnt_d = '0; state_d = ST_ERROR; err_d = 1'b1; errc_d = ERR_TOKEN;
        end else cnt_d = cnt_q + 13'd1;
      end
      ST_DATA: if (spi_done) begin
        dv_d   = 1'b1;
        dout_d = rx;
        idx_d  = cnt_q[8:0];
        if (cnt_q == 13'd511) begin cnt_d = '0; state_d = ST_CRC; end
        else cnt_d = cnt_q + 13'd1;
      end
      ST_CRC: if (spi_done) begin
        if (cnt_q == 13'd1) begin cnt_d = '0; state_d = ST_FINISH; end
        else cnt_d = cnt_q + 13'd1;
      end
      ST_FINISH: if (spi_done) begin done_d = 1'b1; state_d = ST_READY; end
      ST_ERROR:  if (spi_done) state_d = ST_READY;
      default:   state_d = ST_INIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q      <= ST_INIT;
      cnt_q        <= '0;
      addr_q       <= '0;
      init_start_q <= 1'b0;
      sel_q        <= 1'b0;
      dv_q         <= 1'b0;
      dout_q       <= '0;
      idx_q        <= '0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      errc_q       <= ERR_NONE;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      init_start_q <= init_start_d;
      sel_q        <= sel_d;
      dv_q         <= dv_d;
      dout_q       <= dout_d;
      idx_q        <= idx_d;
      done_q       <= done_d;
      err_q        <= err_d;
      errc_q       <= errc_d;
    end
  end

  // The initializer owns the card pins only while it is running.
  assign SCLK       = sel_q ? init_sclk : spi_sclk;
  assign DI         = sel_q ? init_di   : spi_mosi;
  assign CS         = sel_q ? init_cs   : cs_ctl;
  assign init_start = init_start_q;
  assign ready      = (state_q == ST_READY);
  assign data_valid = dv_q;
  assign data_out   = dout_q;
  assign byte_idx   = idx_q;
  assign done       = done_q;
  assign err        = err_q;
  assign err_code   = errc_q;
  assign debug      = {state_q, cnt_q[11:0]};

endmodule

// File: tb/tb_sd_block_reader.sv
// Bench for sd_block_reader: behavioural SD card on the SPI pins, payload
// scoreboard filled as the card queues bytes and drained on data_valid.
module tb_sd_block_reader;
  localparam int CLK_DIV    = 2;
  localparam int R1_POLL    = 8;
  localparam int TOKEN_POLL = 16;

  logic        clk = 1'b0, reset_n = 1'b0;
  logic        init_start, init_done, init_sclk, init_di, init_cs;
  logic        SCLK, DI, CS, DO;
  logic        rd_req;
  logic [31:0] rd_addr;
  logic        ready, data_valid, done, err;
  logic [7:0]  data_out;
  logic [8:0]  byte_idx;
  logic [1:0]  err_code;
  logic [15:0] debug;

  int pass_cnt = 0, total_cnt = 0;

  always #5 clk = ~clk;

  sd_block_reader #(.CLK_DIV(CLK_DIV), .R1_POLL(R1_POLL), .TOKEN_POLL(TOKEN_POLL)) dut (
    .clk(clk), .reset_n(reset_n), .init_start(init_start), .init_done(init_done),
    .init_sclk(init_sclk), .init_di(init_di), .init_cs(init_cs),
    .SCLK(SCLK), .DI(DI), .CS(CS), .DO(DO),
    .rd_req(rd_req), .rd_addr(rd_addr), .ready(ready),
    .data_valid(data_valid), .data_out(data_out), .byte_idx(byte_idx),
    .done(done), .err(err), .err_code(err_code), .debug(debug)
  );

  typedef struct packed { logic [8:0] idx; logic [7:0] data; } exp_t;
  typedef struct { bit no_r1; int r1d; logic [7:0] r1; bit no_tok; int tkd; logic [7:0] tok;
                   logic [1:0] code; int nbytes; } err_case_t;

  // ---- card model: shifts DO on SCLK fall, samples DI on SCLK rise ----
  bit         card_en = 1'b0;
  logic [7:0] card_cur = 8'hFF, card_rx = 8'h00;
  logic [2:0] card_bit = 3'd0;
  int         card_rxbits = 0, card_bytes = 0;
  logic [7:0] resp_q[$];
  logic [7:0] di_log[$];
  exp_t       exp_q[$];
  bit         m_no_r1, m_no_tok;
  int         m_r1d, m_tkd;
  logic [7:0] m_r1, m_tok, m_seed;

  assign DO = (CS || !card_en) ? 1'b1 : card_cur[3'd7 - card_bit];

  task automatic build_resp();
    exp_t e;
    if (m_no_r1) return;
    repeat (m_r1d) resp_q.push_back(8'hFF);
    resp_q.push_back(m_r1);
    if (m_r1 != 8'h00 || m_no_tok) return;
    repeat (m_tkd) resp_q.push_back(8'hFF);
    resp_q.push_back(m_tok);
    if (m_tok != 8'hFE) return;
    for (int i = 0; i < 512; i++) begin
      e.idx = 9'(i); e.data = 8'(i) + m_seed;
      resp_q.push_back(e.data);
      exp_q.push_back(e);
    end
    resp_q.push_back(8'hAB); resp_q.push_back(8'hCD);
  endtask

  always @(posedge SCLK) if (card_en && !CS) begin
    card_rx = {card_rx[6:0], DI};
    card_rxbits++;
    if (card_rxbits == 8) begin
      card_rxbits = 0;
      di_log.push_back(card_rx);
      card_bytes++;
      if (card_bytes == 6) build_resp();
    end
  end

  always @(negedge SCLK) if (card_en && !CS) begin
    if (card_bit == 3'd7) begin
      card_bit = 3'd0;
      if (resp_q.size() > 0) card_cur = resp_q.pop_front(); else card_cur = 8'hFF;
    end else card_bit = card_bit + 3'd1;
  end

  always @(posedge CS) begin
    card_bit = 3'd0; card_cur = 8'hFF; card_rxbits = 0; card_bytes = 0;
  end

  task automatic set_mode(input bit no_r1, input int r1d, input logic [7:0] r1,
                          input bit no_tok, input int tkd, input logic [7:0] tok, input logic [7:0] seed);
    m_no_r1 = no_r1; m_r1d = r1d; m_r1 = r1; m_no_tok = no_tok; m_tkd = tkd; m_tok = tok; m_seed = seed;
    resp_q.delete(); exp_q.delete(); di_log.delete();
    card_en = 1'b1;
  endtask

  task automatic issue_read(input logic [31:0] a);
    @(negedge clk); rd_addr = a; rd_req = 1'b1;
    @(negedge clk); rd_req = 1'b0;
  endtask

  // ---- reset values, then initializer hand-off ----
  task automatic test_reset();
    int hi = 0, pin_bad = 0;
    logic es = 1'b0, ed = 1'b1, ec = 1'b1;
    card_en = 1'b0; init_done = 1'b0; init_sclk = es; init_di = ed; init_cs = ec;
    rd_req = 1'b0; rd_addr = '0; reset_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total_cnt++; if ({init_start, CS, SCLK, DI} !== 4'b0101) $display("FAIL reset_pins: got %b want 0101", {init_start, CS, SCLK, DI}); else pass_cnt++;
    total_cnt++; if ({ready, data_valid, done, err} !== 4'b0000) $display("FAIL reset_flags: got %b want 0000", {ready, data_valid, done, err}); else pass_cnt++;
    total_cnt++; if ({data_out, byte_idx, err_code} !== 19'd0) $display("FAIL reset_data: got %h/%h/%h want 0", data_out, byte_idx, err_code); else pass_cnt++;
    total_cnt++; if (debug !== 16'h0000) $display("FAIL reset_debug: got %h want 0000", debug); else pass_cnt++;
    reset_n = 1'b1;
    for (int c = 0; c < 400 && ready !== 1'b1; c++) begin
      @(negedge clk);
      if (init_start === 1'b1) begin
        hi++;
        if ({SCLK, DI, CS} !== {es, ed, ec}) pin_bad++;
      end
      if (hi == 100) init_done = 1'b1;
      es = 1'($urandom); ed = 1'($urandom); ec = 1'($urandom);
      init_sclk = es; init_di = ed; init_cs = ec;
    end
    total_cnt++; if (hi !== 100) $display("FAIL init_start_len: got %0d cycles want 100", hi); else pass_cnt++;
    total_cnt++; if (pin_bad !== 0) $display("FAIL init_pin_mux: got %0d mismatching cycles want 0", pin_bad); else pass_cnt++;
    total_cnt++; if ({ready, init_start} !== 2'b10) $display("FAIL init_handoff: got ready,init_start=%b want 10", {ready, init_start}); else pass_cnt++;
    init_done = 1'b0;
    repeat (5) @(negedge clk);
    total_cnt++; if ({ready, CS, SCLK, DI} !== 4'b1101) $display("FAIL ready_idle: got %b want 1101", {ready, CS, SCLK, DI}); else pass_cnt++;
  endtask

  // ---- one good read at 0x123 ----
  task automatic test_read_ok();
    int nstb = 0, ndone = 0;
    bit got = 1'b0;
    exp_t e;
    logic [47:0] cmd = '0;
    set_mode(0, 0, 8'h00, 0, 3, 8'hFE, 8'h00);
    issue_read(32'h0000_0123);
    for (int c = 0; c < 25000 && !got; c++) begin
      @(negedge clk);
      if (data_valid === 1'b1) begin
        nstb++; total_cnt++;
        if (exp_q.size() == 0) $display("FAIL read_ok_extra: strobe idx %0d with nothing expected", byte_idx);
        else begin
          e = exp_q.pop_front();
          if ({byte_idx, data_out} !== {e.idx, e.data})
            $display("FAIL read_ok_data: got idx %0d data %h want idx %0d data %h", byte_idx, data_out, e.idx, e.data);
          else pass_cnt++;
        end
      end
      if (done === 1'b1) ndone++;
      got = (ready === 1'b1);
    end
    repeat (50) begin @(negedge clk); if (done === 1'b1) ndone++; end
    for (int i = 0; i < 6 && i < di_log.size(); i++) cmd = {cmd[39:0], di_log[i]};
    total_cnt++; if (!got) $display("FAIL read_ok_timeout: ready never returned"); else pass_cnt++;
    total_cnt++; if (nstb !== 512) $display("FAIL read_ok_strobes: got %0d want 512", nstb); else pass_cnt++;
    total_cnt++; if (ndone !== 1) $display("FAIL read_ok_done: got %0d pulses want 1", ndone); else pass_cnt++;
    total_cnt++; if (cmd !== 48'h51_00_00_01_23_FF) $display("FAIL read_ok_cmd: got %h want 51000001 23ff", cmd); else pass_cnt++;
    total_cnt++; if (di_log.size() !== 525) $display("FAIL read_ok_bytes: got %0d want 525", di_log.size()); else pass_cnt++;
    total_cnt++; if ({err, CS, SCLK, DI} !== 4'b0101) $display("FAIL read_ok_idle: got %b want 0101", {err, CS, SCLK, DI}); else pass_cnt++;
  endtask

  // ---- R1 timeout, bad R1, bad token, token timeout ----
  task automatic test_errors();
    err_case_t ec [4];
    int ndone;
    bit got;
    ec[0] = '{1'b1, 0, 8'hFF, 1'b0, 0, 8'hFF, 2'd1, 14};
    ec[1] = '{1'b0, 2, 8'h04, 1'b0, 0, 8'hFF, 2'd2, 9};
    ec[2] = '{1'b0, 7, 8'h00, 1'b0, 1, 8'hFC, 2'd3, 16};
    ec[3] = '{1'b0, 0, 8'h00, 1'b1, 0, 8'hFF, 2'd3, 23};
    for (int s = 0; s < 4; s++) begin
      ndone = 0; got = 1'b0;
      set_mode(ec[s].no_r1, ec[s].r1d, ec[s].r1, ec[s].no_tok, ec[s].tkd, ec[s].tok, 8'h00);
      issue_read(32'h1000 + 32'(s));
      total_cnt++; if (err !== 1'b0) $display("FAIL err_clear_on_accept[%0d]: got %b want 0", s, err); else pass_cnt++;
      for (int c = 0; c < 3000 && !got; c++) begin
        @(negedge clk);
        if (done === 1'b1) ndone++;
        got = (ready === 1'b1);
      end
      repeat (5) @(negedge clk);
      total_cnt++; if (!got) $display("FAIL err_timeout[%0d]: ready never returned", s); else pass_cnt++;
      total_cnt++; if ({err, err_code} !== {1'b1, ec[s].code}) $display("FAIL err_code[%0d]: got %b/%0d want 1/%0d", s, err, err_code, ec[s].code); else pass_cnt++;
      total_cnt++; if (di_log.size() !== ec[s].nbytes) $display("FAIL err_bytes[%0d]: got %0d want %0d", s, di_log.size(), ec[s].nbytes); else pass_cnt++;
      total_cnt++; if ({ndone, CS} !== {32'd0, 1'b1}) $display("FAIL err_done_cs[%0d]: got done %0d cs %b want 0/1", s, ndone, CS); else pass_cnt++;
    end
  endtask

  // ---- rd_req pulsed mid-DATA must be dropped ----
  task automatic test_back_to_back();
    int nstb = 0, ndone = 0;
    bit got = 1'b0;
    exp_t e;
    logic [47:0] cmd = '0;
    set_mode(0, 1, 8'h00, 0, 0, 8'hFE, 8'h5A);
    issue_read(32'hDEAD_BEEF);
    total_cnt++; if (err !== 1'b0) $display("FAIL b2b_err_clear: got %b want 0", err); else pass_cnt++;
    for (int c = 0; c < 25000 && !got; c++) begin
      @(negedge clk);
      rd_req = 1'b0;
      if (data_valid === 1'b1) begin
        nstb++; total_cnt++;
        if (exp_q.size() == 0) $display("FAIL b2b_extra: strobe idx %0d with nothing expected", byte_idx);
        else begin
          e = exp_q.pop_front();
          if ({byte_idx, data_out} !== {e.idx, e.data})
            $display("FAIL b2b_data: got idx %0d data %h want idx %0d data %h", byte_idx, data_out, e.idx, e.data);
          else pass_cnt++;
        end
        if (byte_idx == 9'd100) begin rd_addr = 32'h0BAD_F00D; rd_req = 1'b1; end
      end
      if (done === 1'b1) ndone++;
      got = (ready === 1'b1);
    end
    repeat (100) begin @(negedge clk); if (done === 1'b1) ndone++; end
    for (int i = 0; i < 6 && i < di_log.size(); i++) cmd = {cmd[39:0], di_log[i]};
    total_cnt++; if (!got) $display("FAIL b2b_timeout: ready never returned"); else pass_cnt++;
    total_cnt++; if ({nstb, ndone} !== {32'd512, 32'd1}) $display("FAIL b2b_counts: got %0d strobes %0d done want 512/1", nstb, ndone); else pass_cnt++;
    total_cnt++; if (cmd !== 48'h51_DE_AD_BE_EF_FF) $display("FAIL b2b_cmd: got %h want 51deadbeefff", cmd); else pass_cnt++;
    total_cnt++; if (di_log.size() !== 523) $display("FAIL b2b_bytes: got %0d want 523", di_log.size()); else pass_cnt++;
    total_cnt++; if ({ready, CS} !== 2'b11) $display("FAIL b2b_idle: got %b want 11", {ready, CS}); else pass_cnt++;
  endtask

  // ---- reset in the middle of payload byte 200 ----
  task automatic test_reset_mid_data();
    int nvalid = 0, hi = 0;
    bit at199 = 1'b0, got = 1'b0;
    set_mode(0, 0, 8'h00, 0, 0, 8'hFE, 8'h33);
    issue_read(32'h0000_0200);
    for (int c = 0; c < 12000 && !at199; c++) begin
      @(negedge clk);
      at199 = (data_valid === 1'b1 && byte_idx == 9'd199);
    end
    total_cnt++; if (!at199) $display("FAIL rst_mid_reach: byte 199 never strobed"); else pass_cnt++;
    repeat (10) begin @(negedge clk); if (data_valid === 1'b1) nvalid++; end
    reset_n = 1'b0;
    @(negedge clk);
    total_cnt++; if ({CS, data_valid, init_start, ready} !== 4'b1000) $display("FAIL rst_mid_pins: got %b want 1000", {CS, data_valid, init_start, ready}); else pass_cnt++;
    total_cnt++; if (debug[15:12] !== 4'd0) $display("FAIL rst_mid_state: got %0d want 0", debug[15:12]); else pass_cnt++;
    card_en = 1'b0; init_done = 1'b0; exp_q.delete(); resp_q.delete();
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 300 && !got; c++) begin
      @(negedge clk);
      if (data_valid === 1'b1) nvalid++;
      if (init_start === 1'b1) hi++;
      if (hi == 20) init_done = 1'b1;
      got = (ready === 1'b1);
    end
    init_done = 1'b0;
    total_cnt++; if (nvalid !== 0) $display("FAIL rst_mid_valid: got %0d strobes want 0", nvalid); else pass_cnt++;
    total_cnt++; if ({got, hi} !== {1'b1, 32'd20}) $display("FAIL rst_mid_reinit: got ready %b init cycles %0d want 1/20", got, hi); else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_read_ok();
    test_errors();
    test_back_to_back();
    test_reset_mid_data();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
